// File: rtl/player_step_controller.sv
// Turns directional button levels into one-at-a-time move codes for the collision
// detector and commits its resolved position. Optional macro: PLAYER_STEP_SYNC_EN.
module player_step_controller #(
    parameter logic [4:0]  START_X       = 5'd2,
    parameter logic [4:0]  START_Y       = 5'd1,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [23:0] REPEAT_CYCLES = 24'd5_000_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_left,
    input  logic       btn_down,
    input  logic [4:0] new_x_pos,
    input  logic [4:0] new_y_pos,
    output logic [2:0] move,
    output logic [4:0] current_x_pos,
    output logic [4:0] current_y_pos,
    output logic       step_done,
    output logic       bumped
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_COMMIT,
        S_COOLDOWN
    } state_t;

    typedef enum logic [2:0] {
        MV_NONE  = 3'b000,
        MV_UP    = 3'b001,
        MV_LEFT  = 3'b010,
        MV_DOWN  = 3'b011,
        MV_RIGHT = 3'b100
    } move_code_t;

    localparam logic [23:0] SETTLE_LAST = 24'(SETTLE_CYCLES - 1);
    localparam logic [23:0] REPEAT_LAST = REPEAT_CYCLES - 24'd1;

    // btn bit order: [3] right, [2] up, [1] left, [0] down
    logic [3:0] btn;

`ifdef PLAYER_STEP_SYNC_EN
    logic [3:0] btn_meta;
    logic [3:0] btn_sync;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            btn_meta <= {btn_right, btn_up, btn_left, btn_down};
            btn_sync <= btn_meta;
        end
    end

    assign btn = btn_sync;
`else
    assign btn = {btn_right, btn_up, btn_left, btn_down};
`endif

    state_t     state;
    move_code_t move_q;
    move_code_t dir_sel;
    logic [4:0] x_q;
    logic [4:0] y_q;
    logic       step_done_q;
    logic       bumped_q;
    logic [23:0] cnt;
    logic [23:0] cnt_inc;
    logic       any_btn;

    assign any_btn = |btn;
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 24'd1;

    always_comb begin
        dir_sel = MV_NONE;
        if (btn[3])
            dir_sel = MV_RIGHT;
        else if (btn[2])
            dir_sel = MV_UP;
        else if (btn[1])
            dir_sel = MV_LEFT;
        else if (btn[0])
            dir_sel = MV_DOWN;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            move_q      <= MV_NONE;
            x_q         <= START_X;
            y_q         <= START_Y;
            step_done_q <= 1'b0;
            bumped_q    <= 1'b0;
            cnt         <= '0;
        end else begin
            step_done_q <= 1'b0;
            bumped_q    <= 1'b0;
            case (state)
                S_IDLE: begin
                    move_q <= MV_NONE;
                    if (enable && any_btn) begin
                        move_q <= dir_sel;
                        cnt    <= '0;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cnt >= SETTLE_LAST)
                        state <= S_COMMIT;
                    else
                        cnt <= cnt_inc;
                end
                S_COMMIT: begin
                    // Detector output is sampled while move is still held.
                    x_q         <= new_x_pos;
                    y_q         <= new_y_pos;
                    step_done_q <= 1'b1;
                    bumped_q    <= (new_x_pos == x_q) && (new_y_pos == y_q);
                    move_q      <= MV_NONE;
                    cnt         <= '0;
                    state       <= S_COOLDOWN;
                end
                S_COOLDOWN: begin
                    move_q <= MV_NONE;
                    if (!any_btn || cnt >= REPEAT_LAST)
                        state <= S_IDLE;
                    else
                        cnt <= cnt_inc;
                end
                default: begin
                    move_q <= MV_NONE;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign move          = move_q;
    assign current_x_pos = x_q;
    assign current_y_pos = y_q;
    assign step_done     = step_done_q;
    assign bumped        = bumped_q;

endmodule
